attributes_result_accum: RTL and testbench
==========================================

Name: attributes_result_accum

Overview:
- Downstream stage of the attributes arithmetic datapath. It consumes the 8-bit XOUT result stream, one sample per valid/ready handshake.
- It accumulates a fixed window of samples into a running sum and tracks the window maximum and minimum.
- Each completed window is presented as a held result packet on an output valid/ready handshake.
- It registers the combinational datapath output and gives the datapath its first sequential boundary.

Parameters:
- DATA_W, 8: sample width; matches XOUT.
- ACC_W, 16: sum width; must be >= DATA_W.
- WINDOW, 4: samples per result; must be >= 2.

Ports:
- CLK  in  1  rising-edge clock.
- RST_N  in  1  asynchronous active-low reset.
- CLEAR  in  1  synchronous abort of the current window/result.
- XIN  in  DATA_W  sample (XOUT of the upstream stage), unsigned.
- IN_VALID  in  1  XIN is valid.
- IN_READY  out  1  block accepts XIN this cycle.
- SUM  out  ACC_W  window sum, modulo 2^ACC_W.
- MAXV  out  DATA_W  window maximum.
- MINV  out  DATA_W  window minimum.
- OVF  out  1  the true window sum exceeded 2^ACC_W-1.
- OUT_VALID  out  1  result packet valid.
- OUT_READY  in  1  consumer takes the packet.

Behaviour:
- Clock/reset: one clock CLK. Reset RST_N is asynchronous and active-low.
- Reset values: state=ACCUM, count=0, SUM=0, MAXV=0, MINV=all ones, OVF=0, OUT_VALID=0, accumulators cleared.
- Accept: a sample is accepted when IN_VALID & IN_READY at a rising CLK edge.
- States: ACCUM and DONE.
- ACCUM:
  - IN_READY=1, OUT_VALID=0.
  - On accept: sum += XIN (zero-extended), with carry-out of bit ACC_W-1 OR'd into the sticky ovf; max/min updated unsigned; count++.
  - The first sample of a window loads sum/max/min directly (ovf=0).
  - On accepting sample number WINDOW: latch SUM/MAXV/MINV/OVF output registers, count=0, go to DONE.
- DONE:
  - OUT_VALID=1. Outputs are held stable until a handshake.
  - IN_READY = OUT_READY; this is the only combinational path, in->out ready.
  - On OUT_READY=1: return to ACCUM. An input accepted in the same cycle becomes sample 1 of the next window, so full throughput has no bubble.
  - On OUT_READY=0: stay in DONE. No input is accepted.
- Latency: OUT_VALID rises on the edge that accepts the WINDOW-th sample (visible the following cycle).
  - Sustained throughput: one sample per cycle, one packet per WINDOW cycles.
- CLEAR (priority over all):
  - Next edge: state=ACCUM, count=0, accumulators reinitialised, OUT_VALID=0.
  - Any pending result is discarded.
  - A sample presented with CLEAR is not accepted; IN_READY=0 while CLEAR=1.
- Boundaries:
  - Sum wraps modulo 2^ACC_W; OVF reports the wrap.
  - Equal samples: MAXV=MINV=value.
  - IN_VALID low mid-window: count holds indefinitely.
  - RST_N low mid-operation: immediate return to reset values, including OUT_VALID=0 asynchronously.
- Sizing: count width is clog2(WINDOW+1).

Decomposition:
- Shared package: state enum (ACCUM, DONE) and a result struct {sum, maxv, minv, ovf} parameterised through a macro in the style of the existing FP struct macro.
- Shared package: a clog2-based width constant helper.
- One natural sub-module: attributes_window_stats, the combinational sum/max/min/ovf next-value logic. It is instantiated once.

Test Plan:
- WINDOW=4, back-to-back XIN 10,20,30,40, OUT_READY=1 -> one cycle after the 4th accept: SUM=100, MAXV=40, MINV=10, OVF=0, OUT_VALID=1 for 1 cycle.
- Same stream with OUT_READY=0 for 5 cycles after completion -> OUT_VALID held; IN_READY=0; SUM=100 stable; next window starts on the OUT_READY edge with no lost or duplicated sample.
- ACC_W=8 (with DATA_W=8), XIN 200,100,50,6 -> SUM=100 (356 mod 256), OVF=1, MAXV=200, MINV=6.
- Continuous stream 1..8 with OUT_READY tied 1 -> packets SUM=10 then SUM=26, zero-bubble input acceptance (IN_READY never low).
- XIN 5,7 accepted, then CLEAR with IN_VALID=1 XIN=9, then 1,2,3,4 -> the 9 is not taken; the packet is SUM=10, MAXV=4, MINV=1.
- RST_N asserted asynchronously while in DONE (OUT_VALID=1) -> OUT_VALID=0 before the next CLK edge; after release the first packet uses only post-reset samples.

Source files
------------

// File: rtl/attributes_result_accum_pkg.sv
// Shared types for the attributes result accumulator: FSM states,
// result packet struct macro and the window counter width helper.
`ifndef ATTRIBUTES_RESULT_ACCUM_PKG_SV
`define ATTRIBUTES_RESULT_ACCUM_PKG_SV

// Result packet, parameterised on sample width DW and sum width AW.
`define ATTR_RESULT_T(DW, AW) \
    struct packed { \
        logic [(AW)-1:0] sum; \
        logic [(DW)-1:0] maxv; \
        logic [(DW)-1:0] minv; \
        logic            ovf; \
    }

package attributes_result_accum_pkg;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_DONE  = 1'b1
    } state_e;

    // Counter must hold 0..window inclusive.
    function automatic int cnt_width(input int window);
        return $clog2(window + 1);
    endfunction

endpackage

`endif

// File: rtl/attributes_window_stats.sv
// Next-value logic for the window sum/max/min/sticky-overflow.
// Ports: first_i (load instead of accumulate), xin_i, acc_*_i (current), nxt_*_o.
module attributes_window_stats #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 16
) (
    input  logic              first_i,
    input  logic [DATA_W-1:0] xin_i,
    input  logic [ACC_W-1:0]  acc_sum_i,
    input  logic [DATA_W-1:0] acc_max_i,
    input  logic [DATA_W-1:0] acc_min_i,
    input  logic              acc_ovf_i,
    output logic [ACC_W-1:0]  nxt_sum_o,
    output logic [DATA_W-1:0] nxt_max_o,
    output logic [DATA_W-1:0] nxt_min_o,
    output logic              nxt_ovf_o
);

    // One extra bit so the carry out of the sum is visible.
    logic [ACC_W:0] sum_ext;

    always_comb begin
        sum_ext = {1'b0, acc_sum_i} + (ACC_W+1)'(xin_i);
        if (first_i) begin
            nxt_sum_o = ACC_W'(xin_i);
            nxt_max_o = xin_i;
            nxt_min_o = xin_i;
            nxt_ovf_o = 1'b0;
        end else begin
            nxt_sum_o = sum_ext[ACC_W-1:0];
            nxt_max_o = (xin_i > acc_max_i) ? xin_i : acc_max_i;
            nxt_min_o = (xin_i < acc_min_i) ? xin_i : acc_min_i;
            nxt_ovf_o = acc_ovf_i | sum_ext[ACC_W];
        end
    end

endmodule

// File: rtl/attributes_result_accum.sv
// Accumulates WINDOW samples of XIN into a held sum/max/min/ovf packet.
// Ports: CLK, RST_N, CLEAR, XIN/IN_VALID/IN_READY in, SUM/MAXV/MINV/OVF/OUT_VALID/OUT_READY out.
module attributes_result_accum
    import attributes_result_accum_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 16,
    parameter int WINDOW = 4
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              CLEAR,
    input  logic [DATA_W-1:0] XIN,
    input  logic              IN_VALID,
    output logic              IN_READY,
    output logic [ACC_W-1:0]  SUM,
    output logic [DATA_W-1:0] MAXV,
    output logic [DATA_W-1:0] MINV,
    output logic              OVF,
    output logic              OUT_VALID,
    input  logic              OUT_READY
);

    localparam int CNT_W = cnt_width(WINDOW);

    typedef `ATTR_RESULT_T(DATA_W, ACC_W) result_t;

    localparam result_t RES_INIT = '{
        sum:  '0,
        maxv: '0,
        minv: '1,
        ovf:  1'b0
    };

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    result_t            acc_q, acc_d;
    result_t            res_q, res_d;
    result_t            nxt;
    logic               accept;
    logic               first;
    logic               last;

    // DONE only takes a sample when the packet leaves in the same cycle.
    assign IN_READY  = !CLEAR && (state_q == ST_ACCUM || OUT_READY);
    assign OUT_VALID = (state_q == ST_DONE);
    assign accept    = IN_VALID && IN_READY;
    assign first     = (count_q == '0);
    assign last      = (count_q == CNT_W'(WINDOW - 1));

    assign SUM  = res_q.sum;
    assign MAXV = res_q.maxv;
    assign MINV = res_q.minv;
    assign OVF  = res_q.ovf;

    attributes_window_stats #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_stats (
        .first_i   (first),
        .xin_i     (XIN),
        .acc_sum_i (acc_q.sum),
        .acc_max_i (acc_q.maxv),
        .acc_min_i (acc_q.minv),
        .acc_ovf_i (acc_q.ovf),
        .nxt_sum_o (nxt.sum),
        .nxt_max_o (nxt.maxv),
        .nxt_min_o (nxt.minv),
        .nxt_ovf_o (nxt.ovf)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        acc_d   = acc_q;
        res_d   = res_q;
        if (CLEAR) begin
            state_d = ST_ACCUM;
            count_d = '0;
            acc_d   = RES_INIT;
        end else begin
            if (state_q == ST_DONE && OUT_READY) begin
                state_d = ST_ACCUM;
            end
            if (accept) begin
                acc_d = nxt;
                if (last) begin
                    res_d   = nxt;
                    count_d = '0;
                    state_d = ST_DONE;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_ACCUM;
            count_q <= '0;
            acc_q   <= RES_INIT;
            res_q   <= RES_INIT;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
        end
    end

endmodule

// File: tb/tb_attributes_result_accum.sv
// Bench for attributes_result_accum: directed plan plus random traffic,
// checked against a sample-queue reference model (ACC_W=16 and ACC_W=8 DUTs).
module tb_attributes_result_accum;

    logic       clk;
    logic       rst_n;
    logic       clear;
    logic [7:0] xin;
    logic       in_valid;
    logic       out_ready;

    logic        in_ready_a, out_valid_a, ovf_a;
    logic [15:0] sum_a;
    logic [7:0]  maxv_a, minv_a;

    logic        in_ready_b, out_valid_b, ovf_b;
    logic [7:0]  sum_b;
    logic [7:0]  maxv_b, minv_b;

    int total = 0;
    int bad   = 0;

    // Reference model: samples of the open window, and the pending packet.
    int q[$];
    bit pend;
    int p_sum, p_max, p_min;

    attributes_result_accum #(.DATA_W(8), .ACC_W(16), .WINDOW(4)) u_a (
        .CLK       (clk),
        .RST_N     (rst_n),
        .CLEAR     (clear),
        .XIN       (xin),
        .IN_VALID  (in_valid),
        .IN_READY  (in_ready_a),
        .SUM       (sum_a),
        .MAXV      (maxv_a),
        .MINV      (minv_a),
        .OVF       (ovf_a),
        .OUT_VALID (out_valid_a),
        .OUT_READY (out_ready)
    );

    attributes_result_accum #(.DATA_W(8), .ACC_W(8), .WINDOW(4)) u_b (
        .CLK       (clk),
        .RST_N     (rst_n),
        .CLEAR     (clear),
        .XIN       (xin),
        .IN_VALID  (in_valid),
        .IN_READY  (in_ready_b),
        .SUM       (sum_b),
        .MAXV      (maxv_b),
        .MINV      (minv_b),
        .OVF       (ovf_b),
        .OUT_VALID (out_valid_b),
        .OUT_READY (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        q.delete();
        pend = 1'b0;
    endtask

    // Apply inputs for one cycle, check against the model, then clock it.
    task automatic cycle(input bit v, input int x, input bit r, input bit c);
        bit exp_ready;
        bit acc;
        in_valid  = v;
        xin       = x[7:0];
        out_ready = r;
        clear     = c;
        #1;
        exp_ready = !c && (!pend || r);
        chk("in_ready_a", 32'(in_ready_a), 32'(exp_ready));
        chk("in_ready_b", 32'(in_ready_b), 32'(exp_ready));
        chk("out_valid_a", 32'(out_valid_a), 32'(pend));
        chk("out_valid_b", 32'(out_valid_b), 32'(pend));
        if (pend) begin
            chk("sum_a", 32'(sum_a), p_sum % 65536);
            chk("ovf_a", 32'(ovf_a), 32'(p_sum > 65535));
            chk("sum_b", 32'(sum_b), p_sum % 256);
            chk("ovf_b", 32'(ovf_b), 32'(p_sum > 255));
            chk("maxv_a", 32'(maxv_a), p_max);
            chk("minv_a", 32'(minv_a), p_min);
            chk("maxv_b", 32'(maxv_b), p_max);
            chk("minv_b", 32'(minv_b), p_min);
        end
        acc = v && exp_ready;
        @(posedge clk);
        #1;
        if (c) begin
            model_reset();
        end else begin
            if (pend && r) pend = 1'b0;
            if (acc) begin
                q.push_back(x & 255);
                if (q.size() == 4) begin
                    p_sum = 0;
                    p_max = 0;
                    p_min = 255;
                    foreach (q[i]) begin
                        p_sum += q[i];
                        if (q[i] > p_max) p_max = q[i];
                        if (q[i] < p_min) p_min = q[i];
                    end
                    pend = 1'b1;
                    q.delete();
                end
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        clear     = 1'b0;
        xin       = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        model_reset();
        #12;
        chk("rst_sum", 32'(sum_a), 0);
        chk("rst_maxv", 32'(maxv_a), 0);
        chk("rst_minv", 32'(minv_a), 255);
        chk("rst_ovf", 32'(ovf_a), 0);
        chk("rst_out_valid", 32'(out_valid_a), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Basic window, consumer always ready.
        cycle(1, 10, 1, 0);
        cycle(1, 20, 1, 0);
        cycle(1, 30, 1, 0);
        cycle(1, 40, 1, 0);
        cycle(0, 0, 1, 0);
        cycle(0, 0, 1, 0);

        // Back-pressure: packet held, input stalled, then resumes.
        cycle(1, 10, 0, 0);
        cycle(1, 20, 0, 0);
        cycle(1, 30, 0, 0);
        cycle(1, 40, 0, 0);
        for (int i = 0; i < 5; i++) cycle(1, 99, 0, 0);
        cycle(1, 1, 1, 0);
        cycle(1, 2, 1, 0);
        cycle(1, 3, 1, 0);
        cycle(1, 4, 1, 0);
        cycle(0, 0, 1, 0);

        // Wraparound in the 8-bit sum instance.
        cycle(1, 200, 1, 0);
        cycle(1, 100, 1, 0);
        cycle(1, 50, 1, 0);
        cycle(1, 6, 1, 0);
        cycle(0, 0, 1, 0);

        // Continuous stream, no bubbles.
        for (int i = 1; i <= 8; i++) cycle(1, i, 1, 0);
        cycle(0, 0, 1, 0);

        // Equal samples.
        for (int i = 0; i < 4; i++) cycle(1, 77, 1, 0);
        cycle(0, 0, 1, 0);

        // CLEAR mid-window discards partial sums and the presented sample.
        cycle(1, 5, 1, 0);
        cycle(1, 7, 1, 0);
        cycle(1, 9, 1, 1);
        cycle(1, 1, 1, 0);
        cycle(0, 0, 1, 0);
        cycle(1, 2, 1, 0);
        cycle(1, 3, 1, 0);
        cycle(1, 4, 1, 0);
        cycle(0, 0, 1, 0);

        // Async reset while a packet is pending.
        cycle(1, 10, 0, 0);
        cycle(1, 20, 0, 0);
        cycle(1, 30, 0, 0);
        cycle(1, 40, 0, 0);
        cycle(0, 0, 0, 0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_out_valid_a", 32'(out_valid_a), 0);
        chk("async_out_valid_b", 32'(out_valid_b), 0);
        chk("async_sum", 32'(sum_a), 0);
        chk("async_minv", 32'(minv_a), 255);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(1, 3, 1, 0);
        cycle(1, 4, 1, 0);
        cycle(1, 5, 1, 0);
        cycle(1, 6, 1, 0);
        cycle(0, 0, 1, 0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0,
                  int'($urandom_range(0, 255)),
                  $urandom_range(0, 2) != 0,
                  $urandom_range(0, 19) == 0);
        end
        cycle(0, 0, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
